// File: rtl/dsp_macc_seq_pkg.sv
// rtl/dsp_macc_seq_pkg.sv - widths, state enum and latched command modes for dsp_macc_sequencer
package dsp_macc_seq_pkg;

    localparam int A_W   = 20;
    localparam int B_W   = 18;
    localparam int Z_W   = 38;
    localparam int SHR_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        ACC,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic             unsigned_a;
        logic             unsigned_b;
        logic             subtract;
        logic             round;
        logic             saturate;
        logic [SHR_W-1:0] shift_right;
    } modes_t;

endpackage

// File: rtl/dsp_macc_seq_lat_ctr.sv
// rtl/dsp_macc_seq_lat_ctr.sv - loadable down-counter that flags done once the DSP pipeline has drained
module dsp_macc_seq_lat_ctr #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic lreset,
    input  logic load,
    output logic done
);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= 3'(LAT);
        end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign done = (cnt == 3'd0);

endmodule

// File: rtl/dsp_macc_sequencer.sv
// rtl/dsp_macc_sequencer.sv - command-driven dot-product sequencer for a shared MACC DSP slice
// Optional abort input enabled by defining DSP_MACC_SEQ_ABORT_EN.
module dsp_macc_sequencer
    import dsp_macc_seq_pkg::*;
#(
    parameter int DSP_LAT = 1,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             lreset,
`ifdef DSP_MACC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_unsigned_a,
    input  logic             cmd_unsigned_b,
    input  logic             cmd_subtract,
    input  logic             cmd_round,
    input  logic             cmd_saturate,
    input  logic [SHR_W-1:0] cmd_shift_right,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [A_W-1:0]   op_a,
    input  logic [B_W-1:0]   op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Z_W-1:0]   res_z,
    output logic [A_W-1:0]   dsp_a,
    output logic [B_W-1:0]   dsp_b,
    output logic             dsp_load_acc,
    output logic [2:0]       dsp_feedback,
    output logic             dsp_unsigned_a,
    output logic             dsp_unsigned_b,
    output logic             dsp_subtract,
    output logic             dsp_round,
    output logic             dsp_saturate,
    output logic [SHR_W-1:0] dsp_shift_right,
    input  logic [Z_W-1:0]   dsp_z
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] count, count_nxt;
    modes_t           modes, modes_nxt;
    logic [A_W-1:0]   dsp_a_nxt;
    logic [B_W-1:0]   dsp_b_nxt;
    logic             load_acc_nxt;
    logic [Z_W-1:0]   res_z_nxt;
    logic             lat_load;
    logic             lat_done;
    logic             op_hs;
    logic             abort_req;

`ifdef DSP_MACC_SEQ_ABORT_EN
    assign abort_req = abort && (state == FIRST || state == ACC || state == DRAIN);
`else
    assign abort_req = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign op_ready  = (state == FIRST || state == ACC) && !abort_req;
    assign res_valid = (state == DONE);
    assign op_hs     = op_valid && op_ready;

    dsp_macc_seq_lat_ctr #(.LAT(DSP_LAT)) u_lat_ctr (
        .clk    (clk),
        .lreset (lreset),
        .load   (lat_load),
        .done   (lat_done)
    );

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        modes_nxt    = modes;
        dsp_a_nxt    = '0;
        dsp_b_nxt    = '0;
        load_acc_nxt = 1'b0;
        res_z_nxt    = res_z;
        lat_load     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    modes_nxt.unsigned_a  = cmd_unsigned_a;
                    modes_nxt.unsigned_b  = cmd_unsigned_b;
                    modes_nxt.subtract    = cmd_subtract;
                    modes_nxt.round       = cmd_round;
                    modes_nxt.saturate    = cmd_saturate;
                    modes_nxt.shift_right = cmd_shift_right;
                    count_nxt             = cmd_len;
                    if (cmd_len == '0) begin
                        res_z_nxt = '0;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FIRST;
                    end
                end
            end
            FIRST, ACC: begin
                // load_acc=0 on the first product restarts the accumulator; stalls in ACC add zero
                load_acc_nxt = (state == ACC);
                if (op_hs) begin
                    dsp_a_nxt = op_a;
                    dsp_b_nxt = op_b;
                    count_nxt = count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        lat_load  = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = ACC;
                    end
                end
            end
            DRAIN: begin
                load_acc_nxt = 1'b1;
                if (lat_done) begin
                    res_z_nxt = dsp_z;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_req) begin
            state_nxt    = IDLE;
            dsp_a_nxt    = '0;
            dsp_b_nxt    = '0;
            load_acc_nxt = 1'b0;
            lat_load     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            state        <= IDLE;
            count        <= '0;
            modes        <= '0;
            dsp_a        <= '0;
            dsp_b        <= '0;
            dsp_load_acc <= 1'b0;
            res_z        <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            modes        <= modes_nxt;
            dsp_a        <= dsp_a_nxt;
            dsp_b        <= dsp_b_nxt;
            dsp_load_acc <= load_acc_nxt;
            res_z        <= res_z_nxt;
        end
    end

    assign dsp_feedback    = 3'b000;
    assign dsp_unsigned_a  = modes.unsigned_a;
    assign dsp_unsigned_b  = modes.unsigned_b;
    assign dsp_subtract    = modes.subtract;
    assign dsp_round       = modes.round;
    assign dsp_saturate    = modes.saturate;
    assign dsp_shift_right = modes.shift_right;

endmodule
